fifo_wptr_full: RTL and testbench

- Write-side control stage of the dual-clock asynchronous FIFO. It sits directly upstream of the FIFO memory and drives that memory's wclken and waddr.
- Owns the binary and Gray write pointers.
- Synchronizes the read-domain Gray pointer into wclk.
- Generates the full, almost-full, fill-level and (optionally) overflow status, all in the wclk domain.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_sync_r2w.sv | 32 +++
 rtl/fifo_wptr_full.sv | 98 +++++++++
 tb/tb_fifo_wptr_full.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO write/read control blocks.
// Helpers work on zero-extended 32-bit values; the width argument bounds the active bits.
package fifo_pkg;

    localparam int ASIZE_DEF        = 4;
    localparam int AFULL_THRESH_DEF = 2;
    localparam int SYNC_STAGES_DEF  = 2;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    function automatic logic [31:0] width_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        logic [31:0] v;
        v = b & width_mask(w);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] v;
        logic [31:0] b;
        v = g & width_mask(w);
        b = v;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ v[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// N-stage reset-to-zero flop chain for Gray pointer crossings; the read side reuses it
// as fifo_sync_w2r. Nothing sits between the stages.
module fifo_sync_r2w
    import fifo_pkg::*;
#(
    parameter int WIDTH  = ASIZE_DEF + 1,
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i - 1];
            end
        end
    end

    assign o_q = r_sync[STAGES - 1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side control of the dual-clock FIFO: write pointers, rptr synchronizer, full/level flags.
// Optional sticky overflow flag enabled by defining FIFO_WOVF_STICKY_EN.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ASIZE        = ASIZE_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    output logic             wclken,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             wovf
);

    localparam int             DEPTH     = depth_of(ASIZE);
    localparam int             PTR_W     = ASIZE + 1;
    localparam logic [ASIZE:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_THRESH);

    logic [ASIZE:0] r_wbin;
    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_wlevel;
    logic           r_wfull;
    logic           r_walmost_full;

    logic [ASIZE:0] w_wq2_rptr;
    logic [ASIZE:0] w_wq2_rbin;
    logic [ASIZE:0] w_wbin_next;
    logic [ASIZE:0] w_wgray_next;
    logic [ASIZE:0] w_level_next;
    logic [ASIZE:0] w_full_ptr;
    logic           w_wclken;

    fifo_sync_r2w #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .i_clk   (wclk),
        .i_rst_n (wrst_n),
        .i_d     (rptr),
        .o_q     (w_wq2_rptr)
    );

    // Reset gates the enable so a write pending at reset assertion never reaches memory.
    assign w_wclken     = winc & ~r_wfull & wrst_n;
    assign w_wbin_next  = r_wbin + {{ASIZE{1'b0}}, w_wclken};
    assign w_wgray_next = PTR_W'(bin2gray(32'(w_wbin_next), PTR_W));
    assign w_wq2_rbin   = PTR_W'(gray2bin(32'(w_wq2_rptr), PTR_W));
    assign w_level_next = w_wbin_next - w_wq2_rbin;
    assign w_full_ptr   = {~w_wq2_rptr[ASIZE:ASIZE-1], w_wq2_rptr[ASIZE-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == w_full_ptr);
            r_walmost_full <= (w_level_next >= AFULL_LVL);
            r_wlevel       <= w_level_next;
        end
    end

`ifdef FIFO_WOVF_STICKY_EN
    logic r_wovf;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf <= 1'b0;
        end else if (winc & r_wfull) begin
            r_wovf <= 1'b1;
        end
    end

    assign wovf = r_wovf;
`else
    assign wovf = 1'b0;
`endif

    assign wclken       = w_wclken;
    assign waddr        = r_wbin[ASIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ASIZE=4, AFULL_THRESH=2, SYNC_STAGES=2).
// Vector table for fill/overfill/first-read/level-wrap, hand sequences for reset and clock-ratio traffic.
module tb_fifo_wptr_full;

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic       exp_wclken;
        logic [3:0] exp_waddr;
        logic [4:0] exp_wptr;
        logic       exp_wfull;
        logic       exp_afull;
        logic [4:0] exp_level;
    } vec_t;

`ifdef FIFO_WOVF_STICKY_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr;
    logic [4:0] rptr_dir;
    logic       wclken;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;
    // Test 3 leaves exactly one read consumed before the rclk model takes over.
    int   rd_count = 1;
    bit   rd_en    = 1'b0;
    vec_t vec [26];

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    fifo_wptr_full #(
        .ASIZE        (4),
        .AFULL_THRESH (2),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr         (rptr),
        .wclken       (wclken),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    // 3:7 wclk:rclk period ratio, rclk offset so its edges never coincide with wclk edges.
    always #15 wclk = ~wclk;
    initial begin
        #2;
        forever #35 rclk = ~rclk;
    end

    assign rptr = rd_en ? g5(rd_count) : rptr_dir;

    initial begin
        forever begin
            @(posedge rclk);
            if (rd_en && (wr_count - rd_count) > 0) begin
                rd_count = rd_count + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            winc     = vec[i].winc;
            rptr_dir = vec[i].rptr;
            @(negedge wclk);
            check($sformatf("v%0d_wclken", i), 32'(wclken), 32'(vec[i].exp_wclken));
            check($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vec[i].exp_waddr));
            @(posedge wclk);
            #1;
            check($sformatf("v%0d_wptr", i), 32'(wptr), 32'(vec[i].exp_wptr));
            check($sformatf("v%0d_wfull", i), 32'(wfull), 32'(vec[i].exp_wfull));
            check($sformatf("v%0d_afull", i), 32'(walmost_full), 32'(vec[i].exp_afull));
            check($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(vec[i].exp_level));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wclken"}, 32'(wclken), 32'd0);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_wptr"}, 32'(wptr), 32'd0);
        check({tag, "_wfull"}, 32'(wfull), 32'd0);
        check({tag, "_afull"}, 32'(walmost_full), 32'd0);
        check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        check({tag, "_wovf"}, 32'(wovf), 32'd0);
    endtask

    initial begin
        int  writes;
        int  occ;
        bit  en;
        bit  full_seen;

        // Fill: 16 writes from empty with rptr held at 0.
        for (int k = 0; k < 16; k++) begin
            vec[k] = '{1'b1, 5'd0, 1'b1, 4'(k), g5(k + 1), (k == 15), (k >= 13), 5'(k + 1)};
        end
        // Overfill: writes refused, pointers hold.
        for (int k = 16; k < 19; k++) begin
            vec[k] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16};
        end
        // One read: rptr Gray 1 reaches wfull on the third edge.
        vec[19] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16};
        vec[20] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16};
        vec[21] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15};
        // rptr = Gray 10000 (binary 31) against wbin = 0: level wraps to 1.
        vec[22] = '{1'b0, 5'b10000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0};
        vec[23] = '{1'b0, 5'b10000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0};
        vec[24] = '{1'b0, 5'b10000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd1};
        vec[25] = '{1'b0, 5'b10000, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd1};

        // Reset state, with winc high to show the enable is gated.
        wrst_n   = 1'b0;
        winc     = 1'b1;
        rptr_dir = 5'd0;
        #5;
        check_all_zero("rst");
        winc = 1'b0;
        do_reset();

        apply(0, 18);
        check("ovf_after_overfill", 32'(wovf), 32'(EXP_OVF));
        apply(19, 21);
        wr_count = 16;

        // Interleaved traffic against the rclk read model.
        writes    = 0;
        full_seen = 1'b0;
        rd_en     = 1'b1;
        for (int cyc = 0; cyc < 400 && writes < 40; cyc++) begin
            winc = (cyc % 4) != 3;
            @(negedge wclk);
            en = wclken;
            if (en) begin
                check("t4_waddr", 32'(waddr), 32'(wr_count % 16));
                check("t4_no_overflow", 32'((wr_count - rd_count) < 16), 32'd1);
            end
            @(posedge wclk);
            #1;
            if (en) begin
                wr_count = wr_count + 1;
                writes   = writes + 1;
            end
            occ = wr_count - rd_count;
            check("t4_wptr", 32'(wptr), 32'(g5(wr_count)));
            check("t4_level_pessimistic", 32'(int'(wlevel) >= occ && int'(wlevel) - occ <= 2), 32'd1);
            if (wfull) begin
                full_seen = 1'b1;
                check("t4_full_occ", 32'(occ >= 14), 32'd1);
            end
        end
        rd_en = 1'b0;
        check("t4_write_budget", 32'(writes), 32'd40);
        check("t4_full_reached", 32'(full_seen), 32'd1);

        // Reset in the middle of a burst.
        winc     = 1'b0;
        rptr_dir = 5'd0;
        do_reset();
        winc = 1'b1;
        repeat (9) @(posedge wclk);
        #1;
        check("t5_level9", 32'(wlevel), 32'd9);
        check("t5_waddr9", 32'(waddr), 32'd9);
        @(negedge wclk);
        wrst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        do_reset();
        #1;
        check("t5_first_wclken", 32'(wclken), 32'd1);
        check("t5_first_waddr", 32'(waddr), 32'd0);
        @(posedge wclk);
        #1;
        check("t5_first_wptr", 32'(wptr), 32'd1);
        check("t5_first_level", 32'(wlevel), 32'd1);
        winc = 1'b0;

        // Level wrap with read pointer ahead modulo 32.
        rptr_dir = 5'b10000;
        do_reset();
        apply(22, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
